// File: rtl/mcp4911_dac_ctrl_pkg.sv
// Shared definitions for the MCP4911 DAC frame sequencer: command word
// layout, FSM state encoding and the command-word builder.
package mcp4911_dac_ctrl_pkg;

    localparam int CMD_W       = 16;
    localparam int DATA_W      = 10;

    // MCP4911 write-command bit positions
    localparam int CMD_WRITE   = 15;
    localparam int CMD_BUF     = 14;
    localparam int CMD_GA_N    = 13;
    localparam int CMD_SHDN_N  = 12;
    localparam int CMD_DATA_HI = 11;
    localparam int CMD_DATA_LO = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CS_UP,
        ST_LDAC
    } state_t;

    // Assemble the 16-bit write command; SHDN_n is the inverse of shutdown.
    function automatic logic [CMD_W-1:0] build_cmd(
        input logic              buf_en,
        input logic              gain_1x,
        input logic              shutdown,
        input logic [DATA_W-1:0] data
    );
        logic [CMD_W-1:0] cmd;
        cmd                          = '0;
        cmd[CMD_WRITE]               = 1'b0;
        cmd[CMD_BUF]                 = buf_en;
        cmd[CMD_GA_N]                = gain_1x;
        cmd[CMD_SHDN_N]              = ~shutdown;
        cmd[CMD_DATA_HI:CMD_DATA_LO] = data;
        return cmd;
    endfunction

endpackage

// File: rtl/mcp4911_dac_ctrl_if.sv
// SPI + LDAC pins between the frame sequencer and the MCP4911.
interface mcp4911_dac_ctrl_if;
    logic dac_cs_n;
    logic dac_sck;
    logic dac_sdi;
    logic dac_ldac_n;

    modport master (output dac_cs_n, dac_sck, dac_sdi, dac_ldac_n);
    modport slave  (input  dac_cs_n, dac_sck, dac_sdi, dac_ldac_n);
endinterface

// File: rtl/mcp4911_dac_ctrl_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector. The pulse is
// high for one clk and is consumed on the 3rd clk edge after the input rises.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);
    // [0],[1]: synchroniser stages, [2]: previous synchronised value
    logic [2:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours.
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], async_in};
    end

    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/mcp4911_dac_ctrl.sv
// Frame sequencer for the MCP4911 10-bit SPI DAC: captures a sample on each
// sample_clk rising edge, shifts the 16-bit write command out in SPI mode 0,
// strobes LDAC and keeps one pending sample for requests arriving mid-frame.
// Every output is a flop fed by a decode of the current state, so the pins
// follow the FSM one clk later with no input-to-output combinational path.
module mcp4911_dac_ctrl
    import mcp4911_dac_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter bit BUF_EN      = 1'b0,
    parameter bit GAIN_1X     = 1'b1,
    parameter int LDAC_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_clk,
    input  logic [DATA_W-1:0]     d_in,
    input  logic                  shutdown,
    mcp4911_dac_ctrl_if.master    dac,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LDAC_W = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [LDAC_W-1:0] LDAC_LAST = LDAC_W'(LDAC_CYCLES - 1);
    // 16 low/high pairs plus one trailing low phase: phases 0..32
    localparam logic [5:0]        PH_LAST   = 6'd32;

    state_t           state, state_nxt;
    logic             req;
    logic [CMD_W-1:0] cmd_now, pend_word, shreg;
    logic             pend_vld;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       ph;
    logic [LDAC_W-1:0] ldac_cnt;
    logic             div_wrap, shift_done, ldac_last;
    logic             cs_n_d, sck_d, sdi_d, ldac_n_d, busy_d, done_d, overrun_d;

    edge_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (sample_clk),
        .rise     (req)
    );

    assign cmd_now    = build_cmd(BUF_EN, GAIN_1X, shutdown, d_in);
    assign div_wrap   = (div_cnt == DIV_LAST);
    assign shift_done = div_wrap && (ph == PH_LAST);
    assign ldac_last  = (ldac_cnt == LDAC_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (req || pend_vld) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (shift_done) state_nxt = ST_CS_UP;
            ST_CS_UP: state_nxt = ST_LDAC;
            ST_LDAC:  if (ldac_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: pending slot, shift register and phase/width counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld  <= 1'b0;
            pend_word <= '0;
            shreg     <= '0;
            div_cnt   <= '0;
            ph        <= '0;
            ldac_cnt  <= '0;
        end else begin
            // A fresh request in IDLE is sent directly; any other request
            // (including one on the last LDAC cycle) lands in the pending slot.
            if (state == ST_IDLE) begin
                if (!req && pend_vld) pend_vld <= 1'b0;
            end else if (req) begin
                pend_word <= cmd_now;
                pend_vld  <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (req)           shreg <= cmd_now;
                    else if (pend_vld) shreg <= pend_word;
                end
                ST_LOAD: begin
                    div_cnt <= '0;
                    ph      <= '0;
                end
                ST_SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        ph      <= ph + 6'd1;
                        // next bit appears as SCK falls after a high phase
                        if (ph[0]) shreg <= {shreg[CMD_W-2:0], 1'b0};
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_CS_UP: ldac_cnt <= '0;
                ST_LDAC:  ldac_cnt <= ldac_cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    // FSM output decode, registered below.
    always_comb begin
        cs_n_d    = (state != ST_SHIFT);
        sck_d     = (state == ST_SHIFT) && ph[0];
        sdi_d     = ((state == ST_LOAD) || (state == ST_SHIFT)) && shreg[CMD_W-1];
        ldac_n_d  = (state != ST_LDAC);
        busy_d    = (state != ST_IDLE);
        done_d    = (state == ST_LDAC) && ldac_last;
        overrun_d = req && (state != ST_IDLE) && pend_vld;
    end

    // Output registers; reset forces CS_n high and SCK low immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac.dac_cs_n   <= 1'b1;
            dac.dac_sck    <= 1'b0;
            dac.dac_sdi    <= 1'b0;
            dac.dac_ldac_n <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            dac.dac_cs_n   <= cs_n_d;
            dac.dac_sck    <= sck_d;
            dac.dac_sdi    <= sdi_d;
            dac.dac_ldac_n <= ldac_n_d;
            busy           <= busy_d;
            frame_done     <= done_d;
            overrun        <= overrun_d;
        end
    end

endmodule

// File: tb/tb_mcp4911_dac_ctrl.sv
// Scoreboard bench for mcp4911_dac_ctrl: stimulus pushes expected SPI words,
// a monitor decodes the SPI pins and checks words and frame timing.
module tb_mcp4911_dac_ctrl;

    localparam int CS_LEN   = 66;
    localparam int LDAC_LEN = 2;
    localparam int F_LEN    = 70;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_clk = 1'b0;
    logic [9:0] d_in = '0;
    logic       shutdown = 1'b0;
    logic       busy, frame_done, overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    int exp_frames = 0;
    int exp_overruns = 0;

    mcp4911_dac_ctrl_if dac_if ();

    mcp4911_dac_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sample_clk (sample_clk),
        .d_in       (d_in),
        .shutdown   (shutdown),
        .dac        (dac_if),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [9:0] d, input logic sd);
        return {1'b0, 1'b0, 1'b1, ~sd, d, 2'b00};
    endfunction

    // ---------------- monitor ----------------
    logic [15:0] mon_word = '0;
    int mon_bits = 0, cs_len = 0, ldac_len = 0, busy_len = 0;
    int mon_done = 0, mon_ovr = 0, mon_sck_rises = 0;
    logic prev_sck = 0, prev_cs = 1, prev_ldac = 1, prev_busy = 0, prev_sdi = 0, prev_done = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_word = '0; mon_bits = 0; cs_len = 0; ldac_len = 0; busy_len = 0;
            prev_sck = 0; prev_cs = 1; prev_ldac = 1; prev_busy = 0; prev_sdi = 0; prev_done = 0;
        end else begin
            if (dac_if.dac_sck && !prev_sck) begin
                mon_sck_rises++;
                check("sdi_stable_at_sck_rise", dac_if.dac_sdi, prev_sdi);
                mon_word = {mon_word[14:0], dac_if.dac_sdi};
                mon_bits++;
            end
            if (!dac_if.dac_cs_n) cs_len++;
            if (dac_if.dac_cs_n && !prev_cs) begin
                check("sck_rises_per_frame", mon_bits, 16);
                check("cs_n_low_len", cs_len, CS_LEN);
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("spi_word", mon_word, exp_q.pop_front());
                mon_bits = 0; cs_len = 0; mon_word = '0;
            end
            if (!dac_if.dac_ldac_n) ldac_len++;
            if (dac_if.dac_ldac_n && !prev_ldac) begin
                check("ldac_n_low_len", ldac_len, LDAC_LEN);
                check("frame_done_on_last_ldac", prev_done, 1);
                ldac_len = 0;
            end
            if (busy) busy_len++;
            if (!busy && prev_busy) begin
                check("busy_len", busy_len, F_LEN);
                busy_len = 0;
            end
            if (frame_done) mon_done++;
            if (overrun) mon_ovr++;
            prev_sck = dac_if.dac_sck; prev_cs = dac_if.dac_cs_n; prev_ldac = dac_if.dac_ldac_n;
            prev_busy = busy; prev_sdi = dac_if.dac_sdi; prev_done = frame_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [9:0] d, input logic sd, input int hi, input int lo);
        @(posedge clk); #1;
        d_in = d;
        shutdown = sd;
        sample_clk = 1'b1;
        repeat (hi) @(posedge clk);
        #1 sample_clk = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    logic [9:0] wave [16] = '{10'h3FF, 10'h000, 10'h3FF, 10'h000,
                              10'h000, 10'h200, 10'h3FF, 10'h200,
                              10'h000, 10'h100, 10'h200, 10'h300,
                              10'h200, 10'h3B5, 10'h3FF, 10'h04A};

    initial begin
        // 1. reset
        #50;
        check("rst_cs_n", dac_if.dac_cs_n, 1);
        check("rst_sck", dac_if.dac_sck, 0);
        check("rst_sdi", dac_if.dac_sdi, 0);
        check("rst_ldac_n", dac_if.dac_ldac_n, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;
        idle(50);
        check("idle_no_sck", mon_sck_rises, 0);
        check("idle_busy", busy, 0);

        // 2. single frame 0x200
        exp_q.push_back(16'h3800); exp_frames++;
        send(10'h200, 1'b0, 6, 6);
        idle(120);
        check("t2_frame_done_cnt", mon_done, exp_frames);

        // 3. full scale, shutdown
        exp_q.push_back(16'h2FFC); exp_frames++;
        send(10'h3FF, 1'b1, 6, 6);
        idle(120);
        check("t3_frame_done_cnt", mon_done, exp_frames);

        // 4. three requests inside one frame: 1 sent, 2 overwritten, 3 sent
        exp_q.push_back(16'h3004); exp_frames++;
        send(10'h001, 1'b0, 6, 6);
        send(10'h002, 1'b0, 6, 6);
        exp_q.push_back(16'h300C); exp_frames++; exp_overruns++;
        send(10'h003, 1'b0, 6, 6);
        idle(200);
        check("t4_overrun_cnt", mon_ovr, exp_overruns);
        check("t4_frame_done_cnt", mon_done, exp_frames);
        check("t4_queue_drained", exp_q.size(), 0);

        // 5. reset at bit 7 with a pending sample
        exp_q.push_back(16'h3554);
        send(10'h155, 1'b0, 6, 6);
        send(10'h0AA, 1'b0, 6, 6);
        begin
            bit reached = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk); #1;
                if (mon_bits >= 7) begin reached = 1; break; end
            end
            check("t5_reach_bit7", reached, 1);
        end
        #2 reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_async_cs_n", dac_if.dac_cs_n, 1);
        check("t5_async_sck", dac_if.dac_sck, 0);
        check("t5_async_busy", busy, 0);
        idle(5);
        #1 reset_n = 1'b1;
        idle(200);
        check("t5_pending_cleared", busy, 0);
        check("t5_no_frame_after_reset", mon_done, exp_frames);
        exp_q.push_back(16'h33C0); exp_frames++;
        send(10'h0F0, 1'b0, 6, 6);
        idle(120);
        check("t5_clean_frame_done", mon_done, exp_frames);

        // 6. LFO-like waveforms at 1088-clk sample period
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(exp_word(wave[i], 1'b0)); exp_frames++;
            send(wave[i], 1'b0, 544, 544);
        end
        idle(50);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_overrun_cnt", mon_ovr, exp_overruns);
        check("final_frame_done_cnt", mon_done, exp_frames);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
